// File: rtl/conv_tap_mac.sv
// conv_tap_mac: convolution multiply-accumulate stage.
// Takes one tap index (i,j,r,c) per accepted beat (r,c innermost). It reads
// image[i+r][j+c] and weight[r][c] from external synchronous-read memories,
// multiplies them, accumulates KH*KW products, and presents one output pixel
// (i,j) per cell behind a valid/ready handshake.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   idx_valid/idx_ready  tap handshake; i,j = output pixel, r,c = kernel tap
//   img_re/img_addr      image read port, img_data arrives one cycle later
//   w_re/w_addr          weight read port, w_data arrives one cycle later
//   out_valid/out_ready  output handshake; out_data tagged with out_i,out_j
//   frame_done           1-cycle pulse after the last pixel of a frame is taken
module conv_tap_mac #(
  parameter int IMG_H  = 4,
  parameter int IMG_W  = 4,
  parameter int KH     = 2,
  parameter int KW     = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     idx_valid,
  output logic                     idx_ready,
  input  logic [3:0]               i,
  input  logic [3:0]               j,
  input  logic [3:0]               r,
  input  logic [3:0]               c,
  output logic                     img_re,
  output logic [7:0]               img_addr,
  input  logic signed [DATA_W-1:0] img_data,
  output logic                     w_re,
  output logic [7:0]               w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [3:0]               out_i,
  output logic [3:0]               out_j,
  output logic                     frame_done
);
  localparam int STAGES = 2;
  localparam logic [4:0] IMG_H5 = 5'(IMG_H);
  localparam logic [4:0] IMG_W5 = 5'(IMG_W);
  localparam logic [3:0] KH4    = 4'(KH);
  localparam logic [3:0] KW4    = 4'(KW);
  localparam logic [7:0] IMG_W8 = 8'(IMG_W);
  localparam logic [7:0] KW8    = 8'(KW);
  localparam logic [3:0] LAST_I = 4'(IMG_H - KH);
  localparam logic [3:0] LAST_J = 4'(IMG_W - KW);

  typedef struct packed {
    logic       pad;    // product must be forced to zero
    logic       first;
    logic       last;
    logic [3:0] i;
    logic [3:0] j;
  } s1_t;

  typedef struct packed {
    logic [2*DATA_W-1:0] prod;
    logic                first;
    logic                last;
    logic [3:0]          i;
    logic [3:0]          j;
  } s2_t;

  logic                       en, accept, kern_ok, img_ok;
  logic [4:0]                 row, col;
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:1]            vld_q;
  s1_t                        s1_d, s1;
  s2_t                        s2;
  logic signed [2*DATA_W-1:0] mult;
  logic signed [ACC_W-1:0]    prod_ext, acc, acc_next;

  // The whole pipeline freezes only while a finished pixel is being refused.
  assign en        = ~(out_valid & ~out_ready);
  assign idx_ready = en & rst_n;
  assign accept    = idx_valid & idx_ready;
  assign vld_pipe  = {vld_q, accept};

  assign row     = {1'b0, i} + {1'b0, r};
  assign col     = {1'b0, j} + {1'b0, c};
  assign kern_ok = (r < KH4) && (c < KW4);
  assign img_ok  = (row < IMG_H5) && (col < IMG_W5);

  // Padding and out-of-kernel taps skip the image read; the stale img_data
  // they would see is masked by s1.pad below.
  assign img_re   = accept & img_ok & kern_ok;
  assign img_addr = img_ok ? ({3'b0, row} * IMG_W8 + {3'b0, col}) : 8'd0;
  assign w_re     = accept;
  assign w_addr   = {4'b0, r} * KW8 + {4'b0, c};

  assign s1_d.pad   = ~(img_ok & kern_ok);
  assign s1_d.first = kern_ok & (r == 4'd0) & (c == 4'd0);
  assign s1_d.last  = kern_ok & (r == KH4 - 4'd1) & (c == KW4 - 4'd1);
  assign s1_d.i     = i;
  assign s1_d.j     = j;

  assign mult     = img_data * w_data;
  assign prod_ext = ACC_W'($signed(s2.prod));
  assign acc_next = s2.first ? prod_ext : acc + prod_ext;  // wraps mod 2^ACC_W

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      s1         <= '0;
      s2         <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_i      <= '0;
      out_j      <= '0;
      frame_done <= 1'b0;
    end else begin
      if (en) begin
        vld_q    <= vld_pipe[STAGES-1:0];
        s1       <= s1_d;
        s2.prod  <= s1.pad ? '0 : mult;
        s2.first <= s1.first;
        s2.last  <= s1.last;
        s2.i     <= s1.i;
        s2.j     <= s1.j;
        if (vld_pipe[STAGES]) acc <= acc_next;
      end
      // A new result may replace one being accepted on the same edge.
      if (en && vld_pipe[STAGES] && s2.last) begin
        out_valid <= 1'b1;
        out_data  <= acc_next;
        out_i     <= s2.i;
        out_j     <= s2.j;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      frame_done <= out_valid & out_ready & (out_i == LAST_I) & (out_j == LAST_J);
    end
  end
endmodule

// File: tb/tb_conv_tap_mac.sv
module tb_conv_tap_mac;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              idx_valid = 1'b0, idx_ready;
  logic [3:0]        i = '0, j = '0, r = '0, c = '0;
  logic              img_re, w_re;
  logic [7:0]        img_addr, w_addr;
  logic signed [7:0] img_data = '0, w_data = '0;
  logic              out_valid, out_ready = 1'b1, frame_done;
  logic signed [17:0] out_data;
  logic [3:0]        out_i, out_j;

  conv_tap_mac dut (
    .clk(clk), .rst_n(rst_n), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .i(i), .j(j), .r(r), .c(c),
    .img_re(img_re), .img_addr(img_addr), .img_data(img_data),
    .w_re(w_re), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_i(out_i), .out_j(out_j), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int fd_cnt = 0;
  int q_d[$], q_i[$], q_j[$];
  logic signed [7:0] img_mem [16];
  logic signed [7:0] w_mem   [64];

  // Synchronous-read memories that hold their data when not enabled.
  always @(posedge clk) begin
    if (img_re) img_data <= img_mem[img_addr[3:0]];
    if (w_re)   w_data   <= w_mem[w_addr[5:0]];
  end

  // Collect accepted outputs late in the cycle, when all inputs are settled.
  always @(negedge clk) begin
    #4;
    if (rst_n && out_valid && out_ready) begin
      q_d.push_back(int'(out_data));
      q_i.push_back(int'(out_i));
      q_j.push_back(int'(out_j));
    end
    if (frame_done) fd_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_mem(input int mode);
    for (int a = 0; a < 64; a++) w_mem[a] = 8'sd7;
    for (int a = 0; a < 16; a++)
      case (mode)
        1: img_mem[a] = 8'sd1;
        2: img_mem[a] = 8'(a);
        default: img_mem[a] = -8'sd128;
      endcase
    for (int a = 0; a < 4; a++)
      case (mode)
        1: w_mem[a] = 8'sd1;
        2: w_mem[a] = (a == 0 || a == 3) ? 8'sd1 : 8'sd0;
        default: w_mem[a] = 8'sd127;
      endcase
  endtask

  task automatic clear_q();
    q_d.delete(); q_i.delete(); q_j.delete();
    fd_cnt = 0;
  endtask

  task automatic send_tap(input int ii, input int jj, input int rr, input int cc);
    bit done = 0;
    int waitc = 0;
    @(negedge clk);
    idx_valid = 1'b1;
    i = 4'(ii); j = 4'(jj); r = 4'(rr); c = 4'(cc);
    while (!done) begin
      #3 done = idx_ready;
      @(posedge clk);
      if (!done) begin
        waitc++;
        if (waitc > 200) begin
          n_chk++; n_fail++;
          $display("FAIL tap_accept: tap %0d,%0d,%0d,%0d never accepted", ii, jj, rr, cc);
          done = 1;
        end else @(negedge clk);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    idx_valid = 1'b0;
    i = '0; j = '0; r = '0; c = '0;
  endtask

  task automatic sweep();
    for (int ci = 0; ci < 3; ci++)
      for (int cj = 0; cj < 3; cj++)
        for (int kr = 0; kr < 2; kr++)
          for (int kc = 0; kc < 2; kc++)
            send_tap(ci, cj, kr, kc);
    idle();
  endtask

  task automatic wait_outs(input int n);
    int cyc = 0;
    while (q_d.size() < n && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    repeat (4) @(negedge clk);
    check("out_count", q_d.size(), n);
  endtask

  typedef struct {
    int ii, jj, rr, cc;
    bit re;
    int addr, waddr;
  } tap_vec_t;

  typedef struct {
    int ii, jj;
    int d1, d2, d3;   // all-ones, ramp/diagonal, -128*127
  } exp_t;

  tap_vec_t tv[7];
  exp_t     ev[9];

  task automatic check_frame(input string tag, input int mode);
    for (int k = 0; k < 9; k++) begin
      if (k < q_d.size()) begin
        check({tag, "_i"}, q_i[k], ev[k].ii);
        check({tag, "_j"}, q_j[k], ev[k].jj);
        check({tag, "_data"}, q_d[k], mode == 1 ? ev[k].d1 : mode == 2 ? ev[k].d2 : ev[k].d3);
      end
    end
  endtask

  initial begin
    tv[0] = '{0, 0, 0, 0, 1'b1, 0, 0};
    tv[1] = '{1, 2, 1, 1, 1'b1, 11, 3};
    tv[2] = '{2, 2, 1, 1, 1'b1, 15, 3};
    tv[3] = '{3, 0, 1, 0, 1'b0, 0, 2};
    tv[4] = '{0, 3, 0, 1, 1'b0, 0, 1};
    tv[5] = '{2, 2, 2, 0, 1'b0, 0, 4};
    tv[6] = '{1, 1, 0, 1, 1'b1, 6, 1};
    for (int k = 0; k < 9; k++) begin
      ev[k].ii = k / 3;
      ev[k].jj = k % 3;
      ev[k].d1 = 4;
      ev[k].d3 = -65024;
    end
    // out(i,j) = p(i,j) + p(i+1,j+1) with p = 4*row+col
    ev[0].d2 = 5;  ev[1].d2 = 7;  ev[2].d2 = 9;
    ev[3].d2 = 13; ev[4].d2 = 15; ev[5].d2 = 17;
    ev[6].d2 = 21; ev[7].d2 = 23; ev[8].d2 = 25;

    // Reset state
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_ij", int'({out_i, out_j}), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_idx_ready", int'(idx_ready), 0);
    check("rst_img_re", int'(img_re), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_mem(1);

    // Read-port table: enables and addresses, incl. padding/out-of-kernel taps
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      idx_valid = 1'b1;
      i = 4'(tv[k].ii); j = 4'(tv[k].jj); r = 4'(tv[k].rr); c = 4'(tv[k].cc);
      #1;
      check($sformatf("tap%0d_img_re", k), int'(img_re), int'(tv[k].re));
      check($sformatf("tap%0d_img_addr", k), int'(img_addr), tv[k].addr);
      check($sformatf("tap%0d_w_re", k), int'(w_re), 1);
      check($sformatf("tap%0d_w_addr", k), int'(w_addr), tv[k].waddr);
    end
    idle();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    clear_q();

    // All ones, full sweep
    load_mem(1);
    sweep();
    wait_outs(9);
    check_frame("s1", 1);
    check("s1_frame_done", fd_cnt, 1);

    // Ramp image, diagonal kernel, with a 5-cycle output stall
    clear_q();
    load_mem(2);
    fork
      sweep();
      begin : stall
        logic [17:0] hd;
        logic [3:0]  hi, hj;
        int cyc = 0;
        while (!out_valid && cyc < 200) begin
          @(negedge clk); cyc++;
        end
        check("stall_saw_valid", int'(out_valid), 1);
        out_ready = 1'b0;
        #1 hd = out_data; hi = out_i; hj = out_j;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          #1;
          check("stall_data", int'(out_data), int'($signed(hd)));
          check("stall_ij", int'({out_i, out_j}), int'({hi, hj}));
          check("stall_valid", int'(out_valid), 1);
          check("stall_idx_ready", int'(idx_ready), 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_outs(9);
    check_frame("s2", 2);

    // Most negative pixel times most positive weight
    clear_q();
    load_mem(3);
    sweep();
    wait_outs(9);
    check_frame("s3", 3);

    // Reset while a result is held and a cell is half done
    clear_q();
    load_mem(1);
    out_ready = 1'b0;
    send_tap(0, 0, 0, 0); send_tap(0, 0, 0, 1);
    send_tap(0, 0, 1, 0); send_tap(0, 0, 1, 1);
    send_tap(0, 1, 0, 0); send_tap(0, 1, 0, 1);
    idle();
    repeat (3) @(negedge clk);
    check("held_valid", int'(out_valid), 1);
    check("held_data", int'(out_data), 4);
    idx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_data", int'(out_data), 0);
    check("arst_idx_ready", int'(idx_ready), 0);
    check("arst_img_re", int'(img_re), 0);
    idx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    clear_q();
    sweep();
    wait_outs(9);
    check_frame("s5", 1);
    check("s5_frame_done", fd_cnt, 1);

    // Out-of-kernel tap inside a cell, then a mostly padded cell
    clear_q();
    load_mem(2);
    send_tap(2, 2, 0, 0); send_tap(2, 2, 0, 1); send_tap(2, 2, 1, 0);
    @(negedge clk);
    idx_valid = 1'b1; i = 4'd2; j = 4'd2; r = 4'd2; c = 4'd0;
    #1 check("pad_tap_img_re", int'(img_re), 0);
    @(posedge clk);
    send_tap(2, 2, 1, 1);
    send_tap(3, 3, 0, 0); send_tap(3, 3, 0, 1);
    send_tap(3, 3, 1, 0); send_tap(3, 3, 1, 1);
    idle();
    wait_outs(2);
    if (q_d.size() >= 2) begin
      check("discard_tap_data", q_d[0], 25);
      check("padded_cell_data", q_d[1], 15);
      check("padded_cell_ij", q_i[1] * 16 + q_j[1], 3 * 16 + 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
